uart_cmd_assembler: RTL and testbench
=====================================

// Module: uart_cmd_assembler
// PURPOSE
//  Consumes the byte stream from the UART receiver (rx_data/rdy/clr_rdy handshake)
//  and packs each pair of bytes into one 16-bit command, high byte first. Sits
//  between the UART receiver and the command processor. Drops a stranded high
//  byte after an inter-byte gap timeout and flags command overrun.
// PARAMETERS
//  GAP_TIMEOUT  104160  clk cycles allowed between high and low byte (4 byte times @19200/50MHz)
//  TMR_W        17      width of gap timer; must satisfy 2**TMR_W > GAP_TIMEOUT
// PORTS
//  clk          in   1   system clock, all state on posedge
//  rst_n        in   1   asynchronous active-low reset
//  rx_data      in   8   byte from UART receiver, valid while rx_rdy=1
//  rx_rdy       in   1   UART receiver byte-ready (level, held until cleared)
//  clr_rx_rdy   out  1   combinational one-cycle clear back to UART receiver
//  clr_cmd_rdy  in   1   command processor has consumed cmd
//  cmd          out  16  assembled command {high_byte, low_byte}
//  cmd_rdy      out  1   cmd valid (level, held until cleared)
//  gap_err      out  1   one-cycle pulse: high byte discarded on timeout
//  overrun      out  1   one-cycle pulse: new cmd written while cmd_rdy was still 1
// BEHAVIOUR
//  Reset: state=IDLE, cmd=16'h0000, hi_byte=8'h00, timer=0, cmd_rdy=0, gap_err=0,
//   overrun=0. clr_rx_rdy is 0 whenever rx_rdy=0 (so 0 out of reset).
//  States: IDLE (awaiting high byte), WAIT_LO (high byte held, awaiting low byte).
//  clr_rx_rdy = rx_rdy in both states: every presented byte is accepted in the
//   cycle it is seen; receiver drops rdy at the next edge, so no byte is taken twice.
//  IDLE & rx_rdy: hi_byte<=rx_data, timer<=0, ->WAIT_LO. cmd/cmd_rdy untouched.
//  WAIT_LO: timer increments by 1 each cycle rx_rdy=0.
//  WAIT_LO & rx_rdy: cmd<={hi_byte,rx_data}, cmd_rdy<=1, ->IDLE. Latency: cmd_rdy
//   high on the edge ending the cycle where low byte's rx_rdy=1.
//   If cmd_rdy was 1 and clr_cmd_rdy=0 that cycle: overrun<=1 for one cycle;
//   cmd is overwritten with the new value (newest command wins).
//  WAIT_LO & !rx_rdy & timer==GAP_TIMEOUT-1: hi_byte discarded, gap_err<=1 one
//   cycle, ->IDLE. Next byte received is treated as a new high byte.
//  Simultaneous rx_rdy and timeout in same cycle: rx_rdy wins, cmd completes, no gap_err.
//  cmd_rdy: set on completion; cleared by clr_cmd_rdy; set and clear in same
//   cycle -> set wins (cmd_rdy stays 1, no overrun pulse).
//  cmd holds its value until the next completion; not cleared by clr_cmd_rdy.
//  Timer saturates never: it is reset to 0 on entry to WAIT_LO and unused in IDLE.
//  Async reset mid-command (WAIT_LO) discards hi_byte; nothing is output.
//  No other state encodings reachable; illegal state -> IDLE.
// TESTING
//  1 Reset released, rx_rdy=0 for 20 cycles -> cmd=0, cmd_rdy=0, clr_rx_rdy=0, no pulses.
//  2 Bytes 8'hA5 then 8'h3C (rx_rdy held until clr) -> clr_rx_rdy exactly 1 cycle per
//    byte, cmd=16'hA53C, cmd_rdy=1 one cycle after 2nd byte; clr_cmd_rdy -> cmd_rdy=0.
//  3 Byte 8'h12, then idle GAP_TIMEOUT cycles, then 8'h34, 8'h56 -> gap_err one-cycle
//    pulse at timeout, then cmd=16'h3456 (8'h12 lost).
//  4 Low byte arriving exactly on timeout cycle (GAP_TIMEOUT-1) -> cmd completes, gap_err=0.
//  5 Commands 16'h0102 then 16'hBEEF without clr_cmd_rdy -> overrun pulse, cmd=16'hBEEF,
//    cmd_rdy=1; repeat with clr_cmd_rdy on completion cycle -> no overrun, cmd_rdy=1.
//  6 Assert rst_n=0 after high byte 8'hFF, release, send 8'h00,8'h07 -> cmd=16'h0007.

Source files
------------

// File: rtl/uart_cmd_assembler.sv
// rtl/uart_cmd_assembler.sv - packs UART receiver bytes pairwise into 16-bit commands
module uart_cmd_assembler #(
    parameter int GAP_TIMEOUT = 104160,
    parameter int TMR_W       = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdy,
    output logic        clr_rx_rdy,
    input  logic        clr_cmd_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    output logic        gap_err,
    output logic        overrun
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] WAIT_LO = 1'b1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GAP_TIMEOUT - 1);

    logic [0:0]       state_q, state_d;
    logic [7:0]       hi_byte_q, hi_byte_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [15:0]      cmd_q, cmd_d;
    logic             cmd_rdy_q, cmd_rdy_d;
    logic             gap_err_q, gap_err_d;
    logic             overrun_q, overrun_d;

    // Every presented byte is consumed in the cycle it is seen.
    assign clr_rx_rdy = rx_rdy;

    always_comb begin
        state_d   = state_q;
        hi_byte_d = hi_byte_q;
        timer_d   = timer_q;
        cmd_d     = cmd_q;
        cmd_rdy_d = cmd_rdy_q & ~clr_cmd_rdy;
        gap_err_d = 1'b0;
        overrun_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_rdy) begin
                    hi_byte_d = rx_data;
                    timer_d   = '0;
                    state_d   = WAIT_LO;
                end
            end
            WAIT_LO: begin
                // A low byte in the timeout cycle still completes the command.
                if (rx_rdy) begin
                    cmd_d     = {hi_byte_q, rx_data};
                    cmd_rdy_d = 1'b1;
                    overrun_d = cmd_rdy_q & ~clr_cmd_rdy;
                    state_d   = IDLE;
                end else if (timer_q == TMR_LAST) begin
                    hi_byte_d = 8'h00;
                    gap_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            hi_byte_q <= 8'h00;
            timer_q   <= '0;
            cmd_q     <= 16'h0000;
            cmd_rdy_q <= 1'b0;
            gap_err_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_byte_q <= hi_byte_d;
            timer_q   <= timer_d;
            cmd_q     <= cmd_d;
            cmd_rdy_q <= cmd_rdy_d;
            gap_err_q <= gap_err_d;
            overrun_q <= overrun_d;
        end
    end

    assign cmd     = cmd_q;
    assign cmd_rdy = cmd_rdy_q;
    assign gap_err = gap_err_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// tb/tb_uart_cmd_assembler.sv - self-checking bench for uart_cmd_assembler
module tb_uart_cmd_assembler;

    localparam int GAP = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_rdy = 1'b0;
    logic        clr_rx_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        gap_err;
    logic        overrun;

    uart_cmd_assembler #(.GAP_TIMEOUT(GAP), .TMR_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_rdy     (rx_rdy),
        .clr_rx_rdy (clr_rx_rdy),
        .clr_cmd_rdy(clr_cmd_rdy),
        .cmd        (cmd),
        .cmd_rdy    (cmd_rdy),
        .gap_err    (gap_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int n_asr = 0;
    int n_fail = 0;

    // Reference model: pending high byte plus the cycle number it arrived in.
    int          cyc = 0;
    logic        m_have_hi = 1'b0;
    logic [7:0]  m_hi = 8'h00;
    int          m_hi_cyc = 0;
    logic [15:0] m_cmd = 16'h0000;
    logic        m_rdy = 1'b0;
    logic        m_gap = 1'b0;
    logic        m_ovr = 1'b0;

    typedef struct {
        logic        r;
        logic [7:0]  d;
        logic        c;
        logic [15:0] e_cmd;
        logic        e_rdy;
        logic        e_gap;
        logic        e_ovr;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_asr++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_have_hi = 1'b0;
        m_cmd     = 16'h0000;
        m_rdy     = 1'b0;
        m_gap     = 1'b0;
        m_ovr     = 1'b0;
    endtask

    task automatic model_step(input logic r, input logic [7:0] d, input logic c);
        m_gap = 1'b0;
        m_ovr = 1'b0;
        if (r) begin
            if (m_have_hi) begin
                m_ovr     = m_rdy && !c;
                m_cmd     = {m_hi, d};
                m_rdy     = 1'b1;
                m_have_hi = 1'b0;
            end else begin
                if (c) m_rdy = 1'b0;
                m_have_hi = 1'b1;
                m_hi      = d;
                m_hi_cyc  = cyc;
            end
        end else begin
            if (c) m_rdy = 1'b0;
            if (m_have_hi && (cyc - m_hi_cyc) == GAP) begin
                m_gap     = 1'b1;
                m_have_hi = 1'b0;
            end
        end
    endtask

    task automatic step(input logic r, input logic [7:0] d, input logic c);
        @(negedge clk);
        rx_rdy      = r;
        rx_data     = d;
        clr_cmd_rdy = c;
        #1;
        chk("clr_rx_rdy", {31'b0, clr_rx_rdy}, {31'b0, r});
        @(posedge clk);
        #1;
        rx_rdy      = 1'b0;
        clr_cmd_rdy = 1'b0;
        model_step(r, d, c);
        cyc++;
        chk("cmd", {16'b0, cmd}, {16'b0, m_cmd});
        chk("cmd_rdy", {31'b0, cmd_rdy}, {31'b0, m_rdy});
        chk("gap_err", {31'b0, gap_err}, {31'b0, m_gap});
        chk("overrun", {31'b0, overrun}, {31'b0, m_ovr});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 8'hA5, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 8'h3C, 1'b0, 16'hA53C, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 16'hA53C, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 8'h01, 1'b0, 16'hA53C, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 8'h02, 1'b0, 16'h0102, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 8'hBE, 1'b0, 16'h0102, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 8'hEF, 1'b0, 16'hBEEF, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 16'hBEEF, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 8'h11, 1'b0, 16'hBEEF, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 8'h22, 1'b1, 16'h1122, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 16'h1122, 1'b0, 1'b0, 1'b0};

        // Reset, then 20 idle cycles
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd", {16'b0, cmd}, 32'h0);
        chk("rst_cmd_rdy", {31'b0, cmd_rdy}, 32'h0);
        chk("rst_clr_rx_rdy", {31'b0, clr_rx_rdy}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b0);

        // Basic pairing and overrun via vector table
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].r, tbl[i].d, tbl[i].c);
            chk($sformatf("tbl%0d_cmd", i), {16'b0, cmd}, {16'b0, tbl[i].e_cmd});
            chk($sformatf("tbl%0d_rdy", i), {31'b0, cmd_rdy}, {31'b0, tbl[i].e_rdy});
            chk($sformatf("tbl%0d_ovr", i), {31'b0, overrun}, {31'b0, tbl[i].e_ovr});
            chk($sformatf("tbl%0d_gap", i), {31'b0, gap_err}, {31'b0, tbl[i].e_gap});
        end

        // Stranded high byte times out, next pair is a fresh command
        step(1'b1, 8'h12, 1'b0);
        for (int k = 1; k <= GAP; k++) begin
            step(1'b0, 8'h00, 1'b0);
            chk("gap_pulse", {31'b0, gap_err}, {31'b0, (k == GAP)});
        end
        step(1'b0, 8'h00, 1'b0);
        chk("gap_one_cycle", {31'b0, gap_err}, 32'h0);
        step(1'b1, 8'h34, 1'b0);
        step(1'b1, 8'h56, 1'b0);
        chk("after_gap_cmd", {16'b0, cmd}, 32'h3456);
        chk("after_gap_rdy", {31'b0, cmd_rdy}, 32'h1);

        // Low byte lands in the final allowed cycle
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'hAA, 1'b0);
        for (int k = 1; k < GAP; k++) step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'hBB, 1'b0);
        chk("edge_cmd", {16'b0, cmd}, 32'hAABB);
        chk("edge_gap", {31'b0, gap_err}, 32'h0);
        step(1'b0, 8'h00, 1'b0);
        chk("edge_gap_next", {31'b0, gap_err}, 32'h0);

        // Reset while a high byte is pending
        step(1'b1, 8'hFF, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        model_reset();
        chk("midrst_cmd", {16'b0, cmd}, 32'h0);
        chk("midrst_rdy", {31'b0, cmd_rdy}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'h07, 1'b0);
        chk("midrst_new_cmd", {16'b0, cmd}, 32'h0007);

        // Randomized bursts with gaps around the timeout
        for (int s = 0; s < 300; s++) begin
            int idle;
            idle = (($urandom_range(0, 3) == 0) ? $urandom_range(GAP - 2, GAP + 3)
                                                 : $urandom_range(0, 3));
            for (int k = 0; k < idle; k++) step(1'b0, 8'h00, ($urandom_range(0, 3) == 0));
            step(1'b1, 8'($urandom), ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asr, n_fail);
        $finish;
    end

endmodule
